// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: instruction width, NOP encoding, fetch FSM
// state encoding and a PC alignment helper.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_ST = 2'd0,
    KILL_ST  = 2'd1,
    HOLD_ST  = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus: the fetch stage masters req/addr, memory
// answers with ready/rdata.
interface if_stage_if;
  import mips_pkg::*;

  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/if_stage_if_id_reg.sv
// Pipeline boundary register (valid/instr/pc_plus4) with load, hold and flush;
// flush dominates hold, hold dominates load.
module if_id_reg
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_flush,
  input  logic               i_hold,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [31:0]        i_pc_plus4,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [31:0]        o_pc_plus4
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_valid    <= 1'b0;
      o_instr    <= NOP_INSTR;
      o_pc_plus4 <= '0;
    end else if (i_flush) begin
      // pc_plus4 is left alone: a bubble carries no address.
      o_valid <= 1'b0;
      o_instr <= NOP_INSTR;
    end else if (i_load && !i_hold) begin
      o_valid    <= 1'b1;
      o_instr    <= i_instr;
      o_pc_plus4 <= i_pc_plus4;
    end
  end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: owns the PC, fetches over a req/ready bus,
// buffers a word across decode stalls and retires killed fetches on redirect.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  if_stage_if.master         imem,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [31:0]        if_id_pc_plus4
);

  fetch_state_e       r_state, w_next_state;
  logic [31:0]        r_pc, w_pc_next;
  logic [31:0]        r_req_addr, w_req_addr_next;
  logic [INSTR_W-1:0] r_skid, w_skid_next;
  logic [INSTR_W-1:0] w_load_instr;
  logic [31:0]        w_pc_plus4;
  logic               w_load;

  assign w_pc_plus4 = r_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= FETCH_ST;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_skid     <= NOP_INSTR;
    end else begin
      r_state    <= w_next_state;
      r_pc       <= w_pc_next;
      r_req_addr <= w_req_addr_next;
      r_skid     <= w_skid_next;
    end
  end

  // NOTE: every output of this block is defaulted first so no path through
  // the case statement can leave a latch behind.
  always_comb begin
    w_next_state    = r_state;
    w_pc_next       = r_pc;
    w_req_addr_next = r_req_addr;
    w_skid_next     = r_skid;
    w_load          = 1'b0;
    w_load_instr    = imem.imem_rdata;
    unique case (r_state)
      FETCH_ST: begin
        if (redirect) begin
          w_pc_next = align_pc(redirect_pc);
          if (!imem.imem_ready) begin
            w_req_addr_next = r_pc;
            w_next_state    = KILL_ST;
          end
        end else if (imem.imem_ready) begin
          if (!stall) begin
            w_load    = 1'b1;
            w_pc_next = w_pc_plus4;
          end else begin
            w_skid_next  = imem.imem_rdata;
            w_next_state = HOLD_ST;
          end
        end
      end
      KILL_ST: begin
        // The bus handshake must complete even though its data is dead.
        if (redirect) w_pc_next = align_pc(redirect_pc);
        if (imem.imem_ready) w_next_state = FETCH_ST;
      end
      HOLD_ST: begin
        if (redirect) begin
          w_pc_next    = align_pc(redirect_pc);
          w_next_state = FETCH_ST;
        end else if (!stall) begin
          w_load       = 1'b1;
          w_load_instr = r_skid;
          w_pc_next    = w_pc_plus4;
          w_next_state = FETCH_ST;
        end
      end
      default: w_next_state = FETCH_ST;
    endcase
  end

  assign imem.imem_req  = rst_n && (r_state != HOLD_ST);
  assign imem.imem_addr = (r_state == KILL_ST) ? r_req_addr : r_pc;

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_flush   (redirect),
    .i_hold    (stall),
    .i_instr   (w_load_instr),
    .i_pc_plus4(w_pc_plus4),
    .o_valid   (if_id_valid),
    .o_instr   (if_id_instr),
    .o_pc_plus4(if_id_pc_plus4)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a cycle-by-cycle vector table plus hand-written
// reset-during-HOLD and PC wrap-around sequences.
module tb_if_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect;
  logic [31:0] redirect_pc;
  logic        rst1_n;
  logic        v0, v1;
  logic [31:0] i0, i1, p0, p1;
  int          n_cmp = 0;
  int          n_err = 0;

  if_stage_if bus0 ();
  if_stage_if bus1 ();

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem(bus0.master),
    .if_id_valid(v0), .if_id_instr(i0), .if_id_pc_plus4(p0)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst_n(rst1_n), .stall(1'b0), .redirect(1'b0),
    .redirect_pc(32'h0), .imem(bus1.master),
    .if_id_valid(v1), .if_id_instr(i1), .if_id_pc_plus4(p1)
  );

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        ready;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic rd, input logic [31:0] rpc,
                     input logic rdy, input logic [31:0] rdata,
                     input logic e_req, input logic [31:0] e_addr,
                     input logic e_v, input logic [31:0] e_i, input logic [31:0] e_p);
    vec_t v;
    v.stall = st;  v.redirect = rd;  v.rpc = rpc;  v.ready = rdy;  v.rdata = rdata;
    v.e_req = e_req;  v.e_addr = e_addr;  v.e_valid = e_v;  v.e_instr = e_i;  v.e_pc4 = e_p;
    vecs.push_back(v);
  endtask

  localparam logic [31:0] BAD = 32'hBAD0_BAD0;

  initial begin
    rst_n = 1'b0;  rst1_n = 1'b0;  stall = 1'b0;  redirect = 1'b0;  redirect_pc = '0;
    bus0.imem_ready = 1'b0;  bus0.imem_rdata = '0;
    bus1.imem_ready = 1'b0;  bus1.imem_rdata = '0;

    //   st rd rpc            rdy rdata          req addr          v  instr          pc4
    add(0, 0, 32'h0,         1, 32'h0,          1, 32'h0,         1, 32'h0,         32'h4);
    add(0, 0, 32'h0,         1, 32'h4,          1, 32'h4,         1, 32'h4,         32'h8);
    add(0, 0, 32'h0,         1, 32'h8,          1, 32'h8,         1, 32'h8,         32'hC);
    add(0, 0, 32'h0,         0, BAD,            1, 32'hC,         1, 32'h8,         32'hC);
    add(0, 0, 32'h0,         0, BAD,            1, 32'hC,         1, 32'h8,         32'hC);
    add(0, 0, 32'h0,         1, 32'hDEAD_000C,  1, 32'hC,         1, 32'hDEAD_000C, 32'h10);
    add(1, 0, 32'h0,         1, 32'h1111_0010,  1, 32'h10,        1, 32'hDEAD_000C, 32'h10);
    add(1, 0, 32'h0,         0, BAD,            0, 32'h0,         1, 32'hDEAD_000C, 32'h10);
    add(0, 0, 32'h0,         0, BAD,            0, 32'h0,         1, 32'h1111_0010, 32'h14);
    add(0, 0, 32'h0,         1, 32'h14,         1, 32'h14,        1, 32'h14,        32'h18);
    add(0, 1, 32'h40,        0, BAD,            1, 32'h18,        0, NOP_INSTR,     32'h18);
    add(0, 0, 32'h0,         1, BAD,            1, 32'h18,        0, NOP_INSTR,     32'h18);
    add(0, 0, 32'h0,         1, 32'h40,         1, 32'h40,        1, 32'h40,        32'h44);
    add(0, 1, 32'h83,        0, BAD,            1, 32'h44,        0, NOP_INSTR,     32'h44);
    add(0, 1, 32'h100,       0, BAD,            1, 32'h44,        0, NOP_INSTR,     32'h44);
    add(0, 0, 32'h0,         1, BAD,            1, 32'h44,        0, NOP_INSTR,     32'h44);
    add(0, 0, 32'h0,         1, 32'h100,        1, 32'h100,       1, 32'h100,       32'h104);
    add(1, 1, 32'h200,       1, BAD,            1, 32'h104,       0, NOP_INSTR,     32'h104);
    add(0, 0, 32'h0,         1, 32'h200,        1, 32'h200,       1, 32'h200,       32'h204);
    add(1, 0, 32'h0,         0, BAD,            1, 32'h204,       1, 32'h200,       32'h204);
    add(1, 0, 32'h0,         1, BAD,            1, 32'h204,       1, 32'h200,       32'h204);
    add(1, 1, 32'h300,       0, BAD,            0, 32'h0,         0, NOP_INSTR,     32'h204);
    add(0, 0, 32'h0,         1, 32'h300,        1, 32'h300,       1, 32'h300,       32'h304);

    // Reset state of the default-PC instance.
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'b0, bus0.imem_req}, 32'h0);
    check("rst_valid", {31'b0, v0}, 32'h0);
    check("rst_instr", i0, NOP_INSTR);
    check("rst_pc4", p0, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[k]) begin
      stall = vecs[k].stall;  redirect = vecs[k].redirect;  redirect_pc = vecs[k].rpc;
      bus0.imem_ready = vecs[k].ready;  bus0.imem_rdata = vecs[k].rdata;
      #1;
      check($sformatf("v%0d_req", k), {31'b0, bus0.imem_req}, {31'b0, vecs[k].e_req});
      if (vecs[k].e_req) check($sformatf("v%0d_addr", k), bus0.imem_addr, vecs[k].e_addr);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid", k), {31'b0, v0}, {31'b0, vecs[k].e_valid});
      check($sformatf("v%0d_instr", k), i0, vecs[k].e_instr);
      check($sformatf("v%0d_pc4", k), p0, vecs[k].e_pc4);
      @(negedge clk);
    end

    // Reset arriving while a stalled word sits in the skid buffer.
    stall = 1'b1;  redirect = 1'b0;  bus0.imem_ready = 1'b1;  bus0.imem_rdata = BAD;
    @(negedge clk);
    check("hold_req", {31'b0, bus0.imem_req}, 32'h0);
    rst_n = 1'b0;  bus0.imem_ready = 1'b0;
    #1;
    check("hold_rst_req", {31'b0, bus0.imem_req}, 32'h0);
    @(negedge clk);
    check("hold_rst_valid", {31'b0, v0}, 32'h0);
    check("hold_rst_pc4", p0, 32'h0);
    rst_n = 1'b1;  stall = 1'b0;  bus0.imem_ready = 1'b1;  bus0.imem_rdata = 32'h0000_0055;
    #1;
    check("post_rst_req", {31'b0, bus0.imem_req}, 32'h1);
    check("post_rst_addr", bus0.imem_addr, 32'h0);
    @(negedge clk);
    check("post_rst_valid", {31'b0, v0}, 32'h1);
    check("post_rst_instr", i0, 32'h0000_0055);
    check("post_rst_pc4", p0, 32'h4);
    bus0.imem_ready = 1'b0;

    // PC wrap-around from the top of the address space.
    rst1_n = 1'b1;
    #1;
    check("wrap_addr0", bus1.imem_addr, 32'hFFFF_FFFC);
    check("wrap_req0", {31'b0, bus1.imem_req}, 32'h1);
    bus1.imem_ready = 1'b1;  bus1.imem_rdata = 32'h0000_1234;
    @(negedge clk);
    check("wrap_valid", {31'b0, v1}, 32'h1);
    check("wrap_instr", i1, 32'h0000_1234);
    check("wrap_pc4", p1, 32'h0000_0000);
    check("wrap_addr1", bus1.imem_addr, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
